sample_conv_engine: RTL and testbench

- Parametrised successor to the single-channel 4-tap sample shift buffer.
- Detects the rising edge of `sample_clk` in the `clk` domain, pushes a selected, pre-scaled input sample into a DEPTH-deep delay line, then runs a sequential multiply-accumulate (MAC) against a writable coefficient bank.
- Presents the four newest taps plus a saturated MAC result.
- Sits between the codec sample ports and downstream network layers as the first convolution stage.

---
 rtl/sample_conv_engine.sv | 207 ++++++++++++++++++++
 tb/tb_sample_conv_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_conv_engine.sv
// Sample delay line with sequential MAC convolution stage.
// Edge-triggered frames, writable coefficient bank, saturated output.
module sample_conv_engine #(
  parameter int W        = 16,
  parameter int DEPTH    = 8,
  parameter int FRAC     = 14,
  parameter int IN_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_clk,
  input  logic signed [W-1:0]        sample_in0,
  input  logic signed [W-1:0]        sample_in1,
  input  logic signed [W-1:0]        sample_in2,
  input  logic signed [W-1:0]        sample_in3,
  input  logic [1:0]                 in_sel,
  input  logic                       coeff_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   coeff_addr,
  input  logic signed [W-1:0]        coeff_data,
  input  logic                       overrun_clr,
  output logic signed [W-1:0]        sample_out0,
  output logic signed [W-1:0]        sample_out1,
  output logic signed [W-1:0]        sample_out2,
  output logic signed [W-1:0]        sample_out3,
  output logic signed [W-1:0]        mac_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = 2 * W;
  localparam int ACCW = 2 * W + AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MAC   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN =
    {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic                    prev_q;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [W-1:0]     dl_q   [DEPTH];
  logic signed [W-1:0]     coef_q [DEPTH];
  logic signed [W-1:0]     so_q   [4];
  logic signed [W-1:0]     mac_q;
  logic                    valid_q;

  logic                    edge_w;
  logic                    busy_w;
  logic                    ovr_set;
  logic signed [W-1:0]     sel_w;
  logic signed [W-1:0]     in_sh_w;
  logic signed [W-1:0]     tap_w;
  logic signed [W-1:0]     cf_w;
  logic signed [PW-1:0]    tap_x;
  logic signed [PW-1:0]    cf_x;
  logic signed [PW-1:0]    prod_w;
  logic signed [ACCW-1:0]  acc_sh;
  logic signed [W-1:0]     sat_w;

  assign edge_w = sample_clk & ~prev_q;
  assign busy_w = (state_q != S_IDLE);

  // Input channel select and pre-scale
  always_comb begin
    sel_w = sample_in0;
    unique case (in_sel)
      2'd0: sel_w = sample_in0;
      2'd1: sel_w = sample_in1;
      2'd2: sel_w = sample_in2;
      2'd3: sel_w = sample_in3;
      default: sel_w = sample_in0;
    endcase
  end

  assign in_sh_w = sel_w >>> IN_SHIFT;

  // Full-width signed product of the current tap and coefficient
  assign tap_w  = dl_q[idx_q];
  assign cf_w   = coef_q[idx_q];
  assign tap_x  = PW'(tap_w);
  assign cf_x   = PW'(cf_w);
  assign prod_w = tap_x * cf_x;

  // Floor-scale the accumulator back to Q format and clamp
  assign acc_sh = acc_q >>> FRAC;

  always_comb begin
    if (acc_sh > SAT_MAX) begin
      sat_w = SAT_MAX[W-1:0];
    end else if (acc_sh < SAT_MIN) begin
      sat_w = SAT_MIN[W-1:0];
    end else begin
      sat_w = acc_sh[W-1:0];
    end
  end

  // Frame sequencing, pending-edge tracking and overrun detection
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    ovr_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (edge_w) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        acc_d   = '0;
        idx_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod_w);
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = S_OUT;
      end
      S_OUT: begin
        // An old pending edge is consumed here; a fresh edge in
        // this cycle starts the next frame or refills pending.
        state_d   = (pending_q | edge_w) ? S_SHIFT : S_IDLE;
        pending_d = pending_q & edge_w;
      end
      default: state_d = S_IDLE;
    endcase
    if (busy_w && state_q != S_OUT && edge_w) begin
      if (pending_q) ovr_set = 1'b1;
      else pending_d = 1'b1;
    end
    overrun_d = ovr_set | (overrun_q & ~overrun_clr);
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= sample_clk;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
    end
  end

  // Delay line advances once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
    end else if (state_q == S_SHIFT) begin
      dl_q[0] <= in_sh_w;
      for (int i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Coefficient bank: identity after reset, writable only when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_q[0] <= W'(2 ** FRAC);
      for (int i = 1; i < DEPTH; i++) coef_q[i] <= '0;
    end else if (!busy_w && coeff_wr_en &&
                 int'(coeff_addr) < DEPTH) begin
      coef_q[coeff_addr] <= coeff_data;
    end
  end

  // Output registers update once per completed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) so_q[i] <= '0;
      mac_q   <= '0;
      valid_q <= 1'b0;
    end else if (state_q == S_OUT) begin
      for (int i = 0; i < 4; i++) so_q[i] <= dl_q[i];
      mac_q   <= sat_w;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign sample_out0 = so_q[0];
  assign sample_out1 = so_q[1];
  assign sample_out2 = so_q[2];
  assign sample_out3 = so_q[3];
  assign mac_out     = mac_q;
  assign out_valid   = valid_q;
  assign busy        = busy_w;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sample_conv_engine.sv
// Directed bench for sample_conv_engine.
// Hand-computed vectors for latency, MAC, saturation, overrun, reset.
module tb_sample_conv_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_clk;
  logic signed [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic [1:0]         in_sel;
  logic               coeff_wr_en;
  logic [2:0]         coeff_addr;
  logic signed [15:0] coeff_data;
  logic               overrun_clr;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic signed [15:0] mac_out;
  logic               out_valid, busy, overrun;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  int vcount = 0;

  sample_conv_engine #(.W(16), .DEPTH(8), .FRAC(14), .IN_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .in_sel(in_sel), .coeff_wr_en(coeff_wr_en),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .overrun_clr(overrun_clr),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3),
    .mac_out(mac_out), .out_valid(out_valid),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (out_valid) vcount <= vcount + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(output int e);
    @(negedge clk);
    sample_clk = 1'b1;
    e = cyc;
    @(negedge clk);
    sample_clk = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic frame(input string tag, input int v, output int lat);
    int e, at;
    sample_in0 = 16'(v);
    pulse(e);
    wait_valid(tag, at);
    lat = at - e;
    repeat (5) @(negedge clk);
  endtask

  task automatic wr_coef(input int a, input int d);
    @(negedge clk);
    coeff_wr_en = 1'b1;
    coeff_addr  = 3'(a);
    coeff_data  = 16'(d);
    @(negedge clk);
    coeff_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int e, at, lat, vb;
    rst = 1'b1;
    sample_clk = 1'b0;
    sample_in0 = '0; sample_in1 = '0;
    sample_in2 = '0; sample_in3 = '0;
    in_sel = 2'd0;
    coeff_wr_en = 1'b0; coeff_addr = '0; coeff_data = '0;
    overrun_clr = 1'b0;
    #2;
    chk("rst_mac", mac_out, 0);
    chk("rst_out0", sample_out0, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single frame latency and identity result
    sample_in0 = 16'sd4000;
    pulse(e);
    chk("t1_busy", busy, 1);
    wait_valid("t1", at);
    chk("t1_lat", at - e, 11);
    chk("t1_mac", mac_out, 1000);
    chk("t1_out0", sample_out0, 1000);
    chk("t1_out1", sample_out1, 0);
    chk("t1_out2", sample_out2, 0);
    chk("t1_out3", sample_out3, 0);
    @(negedge clk);
    chk("t1_pulse", out_valid, 0);
    chk("t1_hold", mac_out, 1000);
    repeat (10) @(negedge clk);

    // 2: four frames fill the taps
    frame("t2a", 400, lat);
    frame("t2b", 800, lat);
    frame("t2c", 1200, lat);
    frame("t2d", 1600, lat);
    chk("t2_out0", sample_out0, 400);
    chk("t2_out1", sample_out1, 300);
    chk("t2_out2", sample_out2, 200);
    chk("t2_out3", sample_out3, 100);
    chk("t2_mac", mac_out, 400);

    // 3: quarter-gain coefficients on four taps
    for (int i = 0; i < 4; i++) wr_coef(i, 4096);
    frame("t3a", 400, lat);
    frame("t3b", 800, lat);
    frame("t3c", 1200, lat);
    frame("t3d", 1600, lat);
    chk("t3_mac", mac_out, 250);
    sample_in0 = 16'sd400;
    pulse(e);
    repeat (3) @(negedge clk);
    chk("t3_busy", busy, 1);
    wr_coef(0, 0);
    wait_valid("t3e", at);
    repeat (5) @(negedge clk);
    frame("t3f", 800, lat);
    frame("t3g", 1200, lat);
    frame("t3h", 1600, lat);
    chk("t3_busy_wr", mac_out, 250);

    // 4: saturation both ways
    for (int i = 0; i < 8; i++) wr_coef(i, 32767);
    for (int i = 0; i < 8; i++) frame("t4p", 32767, lat);
    chk("t4_satp", mac_out, 32767);
    chk("t4_out0p", sample_out0, 8191);
    for (int i = 0; i < 8; i++) frame("t4n", -32768, lat);
    chk("t4_satn", mac_out, -32768);
    chk("t4_out3n", sample_out3, -8192);

    // 5: edges at E, E+3, E+5 give two frames and an overrun
    sample_in0 = 16'sd4000;
    vb = vcount;
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    @(negedge clk);
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    chk("t5_no_ovr", overrun, 0);
    @(negedge clk); sample_clk = 1'b1;
    @(negedge clk); sample_clk = 1'b0;
    chk("t5_ovr", overrun, 1);
    repeat (40) @(negedge clk);
    #1;
    chk("t5_pulses", vcount - vb, 2);
    chk("t5_sticky", overrun, 1);
    chk("t5_idle", busy, 0);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("t5_clr", overrun, 0);

    // 6: asynchronous reset mid-MAC
    pulse(e);
    repeat (4) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_mac", mac_out, 0);
    chk("t6_out0", sample_out0, 0);
    vb = vcount;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t6_no_valid", vcount - vb, 0);
    in_sel = 2'd2;
    sample_in2 = -16'sd800;
    frame("t6", 0, lat);
    chk("t6_lat", lat, 11);
    chk("t6_mac2", mac_out, -200);
    chk("t6_out0b", sample_out0, -200);
    chk("t6_out1b", sample_out1, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
